// File: rtl/arithmetic_circuit_4bit.sv
// arithmetic_circuit_4bit
// Registered 4-function arithmetic unit: D/Cout = A + Y + Cin, where Y is
// chosen from B, ~B, all zeros or all ones by {S1,S0}. One-cycle latency,
// results held between captures. The adder is an explicit ripple-carry chain
// of full adders.
// Optional build macro ARITHMETIC_CIRCUIT_FLAGS_EN adds registered zero and
// two's-complement overflow flags; without it those ports do not exist.

module arithmetic_circuit_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             S0,
    input  logic             S1,
    output logic [WIDTH-1:0] D,
    output logic             Cout,
    output logic             out_valid
`ifdef ARITHMETIC_CIRCUIT_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    // One-bit full adder: returns {carry_out, sum}
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        logic p;
        p = a ^ b;
        return {(a & b) | (ci & p), p ^ ci};
    endfunction

    logic [WIDTH-1:0] y_p0;
    logic [WIDTH-1:0] sum_p0;
    logic [WIDTH:0]   carry_p0;

    // B-side operand selection
    always_comb begin
        y_p0 = B;
        unique case ({S1, S0})
            2'b00:   y_p0 = B;
            2'b01:   y_p0 = ~B;
            2'b10:   y_p0 = '0;
            default: y_p0 = '1;
        endcase
    end

    // Ripple-carry chain: carry[0] is Cin, carry[WIDTH] becomes Cout
    assign carry_p0[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        assign {carry_p0[i+1], sum_p0[i]} = full_add(A[i], y_p0[i], carry_p0[i]);
    end

    // ---- stage boundary p0 -> p1: result register ----
    logic [WIDTH-1:0] d_p1;
    logic             cout_p1;
    logic             vld_p1;

    // Capture the sum on en, otherwise hold; valid pulses the cycle after a capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_p1    <= '0;
            cout_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= en;
            if (en) begin
                d_p1    <= sum_p0;
                cout_p1 <= carry_p0[WIDTH];
            end
        end
    end

    assign D         = d_p1;
    assign Cout      = cout_p1;
    assign out_valid = vld_p1;

`ifdef ARITHMETIC_CIRCUIT_FLAGS_EN
    logic zero_p0;
    logic ovf_p0;
    logic zero_p1;
    logic ovf_p1;

    // Overflow: carry into the MSB differs from carry out of the MSB
    assign zero_p0 = (sum_p0 == '0);
    assign ovf_p0  = carry_p0[WIDTH] ^ carry_p0[WIDTH-1];

    // Flags are captured together with D so they always describe the held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
        end else if (en) begin
            zero_p1 <= zero_p0;
            ovf_p1  <= ovf_p0;
        end
    end

    assign zero = zero_p1;
    assign ovf  = ovf_p1;
`endif

endmodule

// File: tb/tb_arithmetic_circuit_4bit.sv
// Testbench for arithmetic_circuit_4bit: directed cases plus randomized
// stimulus against a behavioural integer model of A + Y + Cin.

module tb_arithmetic_circuit_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         S0 = 1'b0;
    logic         S1 = 1'b0;
    logic [W-1:0] D;
    logic         Cout;
    logic         out_valid;
`ifdef ARITHMETIC_CIRCUIT_FLAGS_EN
    logic         zero;
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state (value the outputs should show after the last edge)
    logic [W-1:0] exp_d = '0;
    logic         exp_c = 1'b0;
    logic         exp_v = 1'b0;
    logic         exp_z = 1'b0;
    logic         exp_o = 1'b0;

    arithmetic_circuit_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S0        (S0),
        .S1        (S1),
        .D         (D),
        .Cout      (Cout),
        .out_valid (out_valid)
`ifdef ARITHMETIC_CIRCUIT_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Integer value of the selected B-side operand
    function automatic int y_value(input int b, input logic s1, input logic s0);
        int full;
        full = (1 << W) - 1;
        case ({s1, s0})
            2'b00:   return b;
            2'b01:   return full - b;
            2'b10:   return 0;
            default: return full;
        endcase
    endfunction

    // Signed interpretation of a W-bit value
    function automatic int as_signed(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    // Advance one clock edge and update the model from the inputs sampled at that edge
    task automatic tick();
        int y;
        int total;
        int stotal;
        @(posedge clk);
        if (!rst_n) begin
            exp_d = '0; exp_c = 1'b0; exp_v = 1'b0; exp_z = 1'b0; exp_o = 1'b0;
        end else begin
            exp_v = en;
            if (en) begin
                y      = y_value(int'(B), S1, S0);
                total  = int'(A) + y + int'(Cin);
                exp_d  = W'(total % (1 << W));
                exp_c  = (total >= (1 << W));
                exp_z  = ((total % (1 << W)) == 0);
                stotal = as_signed(int'(A)) + as_signed(y) + int'(Cin);
                exp_o  = (stotal > (1 << (W - 1)) - 1) || (stotal < -(1 << (W - 1)));
            end
        end
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s1, input logic s0, input logic ci, input logic e);
        A = a; B = b; S1 = s1; S0 = s0; Cin = ci; en = e;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (D !== '0) begin errors++; $display("FAIL reset_D got=%b want=0000", D); end
        checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL reset_Cout got=%b want=0", Cout); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        drive(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        checks++; if ({Cout, D, out_valid} !== 6'b0) begin errors++; $display("FAIL reset_held got=%b want=000000", {Cout, D, out_valid}); end
        rst_n = 1'b1;
        en = 1'b0;
        tick();
    endtask

    task automatic test_ops();
        logic [W:0] table_exp [8];
        logic [2:0] sel;
        table_exp = '{5'b00111, 5'b01000, 5'b10010, 5'b10011,
                      5'b00101, 5'b00110, 5'b10100, 5'b10101};
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            drive(4'b0101, 4'b0010, sel[2], sel[1], sel[0], 1'b1);
            tick();
            checks++;
            if ({Cout, D} !== table_exp[k]) begin
                errors++; $display("FAIL ops_sel%0d got=%b want=%b", k, {Cout, D}, table_exp[k]);
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL ops_valid_sel%0d got=%b want=1", k, out_valid);
            end
        end
        en = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ops_valid_drop got=%b want=0", out_valid); end
    endtask

    task automatic test_wrap();
        drive(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if ({Cout, D} !== 5'b10000) begin errors++; $display("FAIL wrap got=%b want=10000", {Cout, D}); end
`ifdef ARITHMETIC_CIRCUIT_FLAGS_EN
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL wrap_zero got=%b want=1", zero); end
`endif
        en = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        drive(4'b0101, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (D !== 4'b0111) begin errors++; $display("FAIL hold_capture got=%b want=0111", D); end
        for (int k = 0; k < 4; k++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            #2 A = ~A; B = ~B;
            tick();
            checks++;
            if ({D, Cout, out_valid} !== 6'b011100) begin
                errors++; $display("FAIL hold_cycle%0d got=%b want=011100", k, {D, Cout, out_valid});
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if ({Cout, D} !== 5'b11111) begin errors++; $display("FAIL pre_reset got=%b want=11111", {Cout, D}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({Cout, D, out_valid} !== 6'b0) begin errors++; $display("FAIL reset_immediate got=%b want=000000", {Cout, D, out_valid}); end
        tick();
        tick();
        checks++; if ({Cout, D, out_valid} !== 6'b0) begin errors++; $display("FAIL reset_mid_held got=%b want=000000", {Cout, D, out_valid}); end
        rst_n = 1'b1;
        drive(4'b0011, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if ({Cout, D, out_valid} !== 6'b001111) begin errors++; $display("FAIL first_capture got=%b want=001111", {Cout, D, out_valid}); end
    endtask

`ifdef ARITHMETIC_CIRCUIT_FLAGS_EN
    task automatic test_flags();
        drive(4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if ({Cout, D, ovf} !== 6'b010001) begin errors++; $display("FAIL flags_ovf got=%b want=010001", {Cout, D, ovf}); end
        drive(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if ({Cout, D, ovf, zero} !== 7'b0111100) begin errors++; $display("FAIL flags_dec got=%b want=0111100", {Cout, D, ovf, zero}); end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 1000; k++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0));
            tick();
            checks++; if (D !== exp_d) begin errors++; $display("FAIL rand_D iter=%0d got=%b want=%b", k, D, exp_d); end
            checks++; if (Cout !== exp_c) begin errors++; $display("FAIL rand_Cout iter=%0d got=%b want=%b", k, Cout, exp_c); end
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rand_valid iter=%0d got=%b want=%b", k, out_valid, exp_v); end
`ifdef ARITHMETIC_CIRCUIT_FLAGS_EN
            checks++; if (zero !== exp_z) begin errors++; $display("FAIL rand_zero iter=%0d got=%b want=%b", k, zero, exp_z); end
            checks++; if (ovf !== exp_o) begin errors++; $display("FAIL rand_ovf iter=%0d got=%b want=%b", k, ovf, exp_o); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_wrap();
        test_hold();
        test_reset_mid();
`ifdef ARITHMETIC_CIRCUIT_FLAGS_EN
        test_flags();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
